// File: rtl/fp_norm_pkg.sv
// Shared types for the floating-point normalization pipeline.
package fp_norm_pkg;
  localparam int unsigned MW        = 32;
  localparam int unsigned CW        = 5;
  // Widest exponent the stage register can carry (EW must stay <= EXP_MAX_W-2).
  localparam int unsigned EXP_MAX_W = 16;

  typedef logic [CW-1:0] lzc_t;

  typedef struct packed {
    logic                 sign;
    logic [EXP_MAX_W-1:0] exp;
    logic [MW-1:0]        mant;
    lzc_t                 cnt;
    logic                 zero;
  } stage_t;
endpackage

// File: rtl/fp_norm_if.sv
// Input/output handshake bundle for fp_norm_pipe; slave is the pipeline side.
interface fp_norm_if
  import fp_norm_pkg::*;
#(
  parameter int unsigned EW = 10
);
  logic          in_valid;
  logic          in_ready;
  logic          in_sign;
  logic [EW-1:0] in_exp;
  logic [MW-1:0] in_mant;
  logic          out_valid;
  logic          out_ready;
  logic          out_sign;
  logic [EW-1:0] out_exp;
  logic [MW-1:0] out_mant;
  logic          out_zero;
  logic          out_uf;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_uf
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_uf
  );
endinterface

// File: rtl/lzc_32.sv
// 32-bit leading-zero counter; v=0 flags an all-zero word (c is then 0).
module lzc_32
  import fp_norm_pkg::*;
(
  input  logic [MW-1:0] a,
  output lzc_t          c,
  output logic          v
);
  always_comb begin
    c = '0;
    v = |a;
    // Ascending scan: the highest set bit is the last one to write c.
    for (int i = 0; i < MW; i++) begin
      if (a[i]) c = CW'(MW - 1 - i);
    end
  end
endmodule

// File: rtl/fp_norm_pipe.sv
// Two-stage mantissa normalizer: stage 1 counts leading zeros, stage 2 shifts and adjusts the exponent.
// Optional macro FP_NORM_SUBNORM_EN clamps the shift so small exponents produce subnormal results.
module fp_norm_pipe
  import fp_norm_pkg::*;
#(
  parameter int unsigned EW = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  fp_norm_if.slave bus
);
  stage_t        s1_d;
  stage_t        s1_q;
  logic          s1_valid;
  logic          s1_adv;
  logic          s2_adv;
  lzc_t          lz_c;
  logic          lz_v;

  logic [EW:0]   exp_ext;
  logic [EW:0]   shift_ext;
  logic [EW:0]   diff;
  lzc_t          shift;
  logic [MW-1:0] mant_sh;
  logic [MW-1:0] mant_nx;
  logic [EW-1:0] exp_nx;
  logic          uf_nx;
  logic          unused_exp_hi;

  lzc_32 u_lzc (
    .a (bus.in_mant),
    .c (lz_c),
    .v (lz_v)
  );

  assign s2_adv       = !bus.out_valid || bus.out_ready;
  assign s1_adv       = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.in_sign;
    s1_d.exp  = EXP_MAX_W'($signed(bus.in_exp));
    s1_d.mant = bus.in_mant;
    s1_d.cnt  = lz_c;
    s1_d.zero = !lz_v;
  end

  // Stage 1 register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) s1_q <= s1_d;
    end
  end

  // Bits above EW are only sign extension of the stored exponent.
  assign unused_exp_hi = ^s1_q.exp[EXP_MAX_W-1:EW+1];
  assign exp_ext       = s1_q.exp[EW:0];

  // Stage 2 combinational: shift amount, shifter and exponent adjust.
  always_comb begin
`ifdef FP_NORM_SUBNORM_EN
    logic [EW:0] lim;
    lim   = exp_ext - (EW+1)'(1);
    shift = '0;
    if (!exp_ext[EW] && exp_ext != '0) begin
      shift = (lim < (EW+1)'(s1_q.cnt)) ? CW'(lim) : s1_q.cnt;
    end
`else
    shift = s1_q.cnt;
`endif
    shift_ext = (EW+1)'(shift);
    mant_sh   = s1_q.mant << shift;
    diff      = exp_ext - shift_ext;
`ifdef FP_NORM_SUBNORM_EN
    uf_nx     = !s1_q.zero && (diff[EW] || diff == '0 || !mant_sh[MW-1]);
`else
    uf_nx     = !s1_q.zero && (diff[EW] || diff == '0);
`endif
    exp_nx    = (s1_q.zero || uf_nx) ? '0 : diff[EW-1:0];
    mant_nx   = s1_q.zero ? '0 : mant_sh;
  end

  // Stage 2 register doubles as the output register; holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.out_sign  <= 1'b0;
      bus.out_exp   <= '0;
      bus.out_mant  <= '0;
      bus.out_zero  <= 1'b0;
      bus.out_uf    <= 1'b0;
    end else if (s2_adv) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.out_sign <= s1_q.sign;
        bus.out_exp  <= exp_nx;
        bus.out_mant <= mant_nx;
        bus.out_zero <= s1_q.zero;
        bus.out_uf   <= uf_nx;
      end
    end
  end
endmodule

// File: doc/fp_norm_pipe.md
FP_NORM_PIPE -- requirements
Module: fp_norm_pipe

Interface
REQ-001 Parameter EW, default 10: signed two's-complement biased exponent width.
REQ-002 Parameter MW, fixed at 32: mantissa width; other values are unsupported.
REQ-003 clock  input  1  Sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  Asynchronous, active-low reset.
REQ-005 in_valid  input  1  Input beat present.
REQ-006 in_ready  output  1  Block accepts the beat this cycle.
REQ-007 in_sign  input  1  Sign, passed through unchanged.
REQ-008 in_exp  input  EW  Biased exponent before normalization, signed.
REQ-009 in_mant  input  32  Unnormalized mantissa.
REQ-010 out_valid  output  1  Output beat present.
REQ-011 out_ready  input  1  Downstream accepts the beat.
REQ-012 out_sign  output  1  Registered sign.
REQ-013 out_exp  output  EW  Adjusted exponent.
REQ-014 out_mant  output  32  Normalized mantissa; bit 31 set unless zero or subnormal.
REQ-015 out_zero  output  1  in_mant was zero.
REQ-016 out_uf  output  1  Underflow or subnormal result.

Function
REQ-017 The block SHALL be a two-stage pipeline with a latency of exactly 2 cycles from the in_valid&in_ready edge to out_valid when there is no stall.
REQ-018 Stage 1 SHALL register sign, exp and mant together with the 5-bit leading-zero count and the all-zero indication of in_mant.
REQ-019 Stage 2 SHALL register mant shifted left by the applied shift, exp minus the applied shift (EW-bit signed), and the flags.
REQ-020 Each stage SHALL advance when its successor is empty or advancing: s2 advances on !out_valid|out_ready; s1 advances on !s1_valid|s2_advance.
REQ-021 in_ready SHALL equal the s1 advance condition, which is combinational from out_ready; a full pipe with out_ready=1 SHALL sustain 1 beat per cycle.
REQ-022 While out_valid=1 and out_ready=0, all out_* signals SHALL hold stable.
REQ-023 For a zero mantissa, the block SHALL output out_mant=0, out_exp=0, out_zero=1, out_uf=0, with out_sign passed through.
REQ-024 For a nonzero mantissa, the applied shift SHALL equal the leading-zero count (0..31), and no mantissa bits SHALL be lost.
REQ-025 If in_exp-shift < 1 and FP_NORM_SUBNORM_EN is undefined, the block SHALL output out_uf=1 and out_exp=0; out_mant stays fully normalized.
REQ-026 Simultaneous input accept and output drain SHALL neither lose nor duplicate beats.

Reset
REQ-027 While reset=0, the block SHALL clear the s1 and s2 valid bits and drive out_valid=0, out_mant=0, out_exp=0, out_sign=0, out_zero=0 and out_uf=0.
REQ-028 Reset asserted mid-operation SHALL discard in-flight beats; in_ready SHALL be 1 in the first cycle after reset release.

Configuration
REQ-029 Macro FP_NORM_SUBNORM_EN defined: applied shift SHALL be min(count, in_exp-1) if in_exp>=1, else 0.
REQ-030 With FP_NORM_SUBNORM_EN defined and out_mant[31]=0 on a nonzero result, out_exp SHALL be 0 and out_uf SHALL be 1.
REQ-031 Macro FP_NORM_SUBNORM_EN undefined: the block SHALL behave as in REQ-024/REQ-025, and the clamp logic SHALL be absent.

Structure
REQ-032 Package fp_norm_pkg SHALL hold MW=32, the 5-bit count typedef, and a struct for the stage registers {sign, exp, mant, cnt, zero}.
REQ-033 The leading-zero count SHALL come from one instantiated sub-module, lzc_32 (outputs c[4:0], v), in stage 1.
REQ-034 The shifter and exponent subtract SHALL be inline in stage 2.

Verification
REQ-035 in_mant=0x00010000, in_exp=20 -> after 2 cycles out_mant=0x80000000, out_exp=5, out_uf=0.
REQ-036 in_mant=0, sign=1 -> out_zero=1, out_mant=0, out_exp=0, out_sign=1.
REQ-037 in_mant=0x00000001, in_exp=10, macro off -> out_mant=0x80000000, out_exp=0, out_uf=1.
REQ-038 in_mant=0x00000001, in_exp=10, macro on -> shift 9, out_mant=0x00000200, out_exp=0, out_uf=1.
REQ-039 Stream of 8 beats with out_ready toggled 1,0,0,1... -> all 8 delivered in order, outputs stable while stalled, in_ready=0 only with a full pipe and out_ready=0.
REQ-040 reset=0 pulse with 2 beats in flight -> out_valid=0 immediately, no stale beat after release.
